// File: rtl/cpu_pkg.sv
// Shared RV32IC core constants: data/register widths, write-back source indices
// and the arbitration mode type used by the write-back source arbiter.
package cpu_pkg;

    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    localparam logic [4:0] REG_X0 = 5'd0;

    localparam int WB_SRC_ALU  = 0;
    localparam int WB_SRC_LOAD = 1;
    localparam int WB_SRC_LINK = 2;

    typedef enum logic {
        ARB_FIXED = 1'b0,
        ARB_RR    = 1'b1
    } arb_mode_e;

    // Increment an index modulo n (n >= 1).
    function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
        return ((i + 32'd1) >= n) ? 32'd0 : (i + 32'd1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Masked priority picker: first requester found scanning upward from the start
// index (ptr in round-robin mode, 0 in fixed mode), wrapping modulo N.
module rr_pick
    import cpu_pkg::*;
#(
    parameter int N     = 3,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    input  arb_mode_e        mode,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    int base_s;
    int cand_s;

    // Scan candidates in rotated order; the first requester wins.
    always_comb begin
        gnt    = '0;
        idx    = '0;
        any    = 1'b0;
        cand_s = 0;
        if (mode == ARB_RR) begin
            base_s = int'(ptr);
        end else begin
            base_s = 0;
        end
        // An out-of-range pointer falls back to index 0 rather than skipping sources.
        if (base_s >= N) begin
            base_s = 0;
        end else begin
            base_s = base_s;
        end
        for (int k = 0; k < N; k++) begin
            cand_s = base_s + k;
            if (cand_s >= N) begin
                cand_s = cand_s - N;
            end else begin
                cand_s = cand_s;
            end
            if (!any && req[IDX_W'(cand_s)]) begin
                any                 = 1'b1;
                gnt[IDX_W'(cand_s)] = 1'b1;
                idx                 = IDX_W'(cand_s);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/wb_src_arbiter.sv
// Write-back source arbiter: grants one producer per cycle into a one-entry
// output stage that drives the register-file write port.
module wb_src_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_SRC = 3,
    parameter int XLEN    = cpu_pkg::XLEN,
    parameter int RADDR_W = cpu_pkg::RADDR_W,
    parameter int RR_MODE = 1,
    localparam int SEL_W  = $clog2(NUM_SRC)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_SRC-1:0]         src_valid,
    input  logic [NUM_SRC*RADDR_W-1:0] src_rd,
    input  logic [NUM_SRC*XLEN-1:0]    src_data,
    output logic [NUM_SRC-1:0]         src_ready,
    input  logic                       wb_stall,
    input  logic                       flush,
    output logic                       rf_we,
    output logic [RADDR_W-1:0]         rf_waddr,
    output logic [XLEN-1:0]            rf_wdata,
    output logic [SEL_W-1:0]           rf_sel,
    output logic                       wb_busy
);

    localparam arb_mode_e ARB_MODE = (RR_MODE != 0) ? ARB_RR : ARB_FIXED;

    logic               out_valid_q, out_valid_d;
    logic [RADDR_W-1:0] out_rd_q,    out_rd_d;
    logic [XLEN-1:0]    out_data_q,  out_data_d;
    logic [SEL_W-1:0]   out_sel_q,   out_sel_d;
    logic [SEL_W-1:0]   ptr_q,       ptr_d;

    logic               can_accept_s;
    logic [NUM_SRC-1:0] req_s;
    logic [NUM_SRC-1:0] gnt_s;
    logic [SEL_W-1:0]   pick_idx_s;
    logic               pick_any_s;

    // The stage can take a new entry when it is empty or draining; reset and flush block grants.
    assign can_accept_s = (~out_valid_q | ~wb_stall) & ~flush & ~rst;
    assign req_s        = can_accept_s ? src_valid : '0;

    rr_pick #(
        .N     (NUM_SRC),
        .IDX_W (SEL_W)
    ) u_pick (
        .req  (req_s),
        .ptr  (ptr_q),
        .mode (ARB_MODE),
        .gnt  (gnt_s),
        .idx  (pick_idx_s),
        .any  (pick_any_s)
    );

    assign src_ready = gnt_s;
    assign wb_busy   = out_valid_q;
    assign rf_we     = out_valid_q & ~wb_stall & ~rst & (out_rd_q != RADDR_W'(REG_X0));
    assign rf_waddr  = out_rd_q;
    assign rf_wdata  = out_data_q;
    assign rf_sel    = out_sel_q;

    // Next-state for the output stage and round-robin pointer.
    always_comb begin
        out_valid_d = out_valid_q;
        out_rd_d    = out_rd_q;
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (pick_any_s) begin
            out_valid_d = 1'b1;
            out_rd_d    = src_rd[int'(pick_idx_s)*RADDR_W +: RADDR_W];
            out_data_d  = src_data[int'(pick_idx_s)*XLEN +: XLEN];
            out_sel_d   = pick_idx_s;
            if (ARB_MODE == ARB_RR) begin
                ptr_d = SEL_W'(wrap_inc(32'(pick_idx_s), NUM_SRC));
            end else begin
                ptr_d = ptr_q;
            end
        end else if (out_valid_q && !wb_stall) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Stage and pointer registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_rd_q    <= '0;
            out_data_q  <= '0;
            out_sel_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_rd_q    <= out_rd_d;
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

endmodule

// File: tb/tb_wb_src_arbiter.sv
// Bench for wb_src_arbiter: directed vector table, fixed-mode fairness sequence
// and randomized traffic checked against a behavioural model of both modes.
module tb_wb_src_arbiter;

    localparam int NS = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic [NS-1:0] valid;
    logic [14:0]   rd_bus;
    logic [95:0]   data_bus;
    logic          stall, flush;

    logic [2:0]  rdy_rr,   rdy_fx;
    logic        we_rr,    we_fx;
    logic [4:0]  waddr_rr, waddr_fx;
    logic [31:0] wdata_rr, wdata_fx;
    logic [1:0]  sel_rr,   sel_fx;
    logic        busy_rr,  busy_fx;

    int checks = 0;
    int errors = 0;

    // model state, index 0 = round-robin DUT, 1 = fixed-priority DUT
    logic        m_valid [2];
    logic [4:0]  m_rd    [2];
    logic [31:0] m_data  [2];
    int          m_sel   [2];
    int          m_ptr   [2];

    always #5 clk = ~clk;

    wb_src_arbiter #(.NUM_SRC(NS), .XLEN(32), .RADDR_W(5), .RR_MODE(1)) u_rr (
        .clk(clk), .rst(rst), .src_valid(valid), .src_rd(rd_bus), .src_data(data_bus),
        .src_ready(rdy_rr), .wb_stall(stall), .flush(flush), .rf_we(we_rr),
        .rf_waddr(waddr_rr), .rf_wdata(wdata_rr), .rf_sel(sel_rr), .wb_busy(busy_rr));

    wb_src_arbiter #(.NUM_SRC(NS), .XLEN(32), .RADDR_W(5), .RR_MODE(0)) u_fx (
        .clk(clk), .rst(rst), .src_valid(valid), .src_rd(rd_bus), .src_data(data_bus),
        .src_ready(rdy_fx), .wb_stall(stall), .flush(flush), .rf_we(we_fx),
        .rf_waddr(waddr_fx), .rf_wdata(wdata_fx), .rf_sel(sel_fx), .wb_busy(busy_fx));

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [4:0]  rd0, rd1, rd2;
        logic [31:0] base;
        logic        stall, flush;
        logic [2:0]  e_ready;
        logic        e_we;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [1:0]  e_sel;
        logic        e_busy;
    } vec_t;

    vec_t vt [28];

    function automatic vec_t mk(input logic r, input logic [2:0] v, input logic [4:0] a0,
                                input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] b,
                                input logic s, input logic f, input logic [2:0] er, input logic ew,
                                input logic [4:0] ewa, input logic [31:0] ewd, input logic [1:0] es,
                                input logic eb);
        vec_t x;
        x.rst = r; x.valid = v; x.rd0 = a0; x.rd1 = a1; x.rd2 = a2; x.base = b;
        x.stall = s; x.flush = f; x.e_ready = er; x.e_we = ew; x.e_waddr = ewa;
        x.e_wdata = ewd; x.e_sel = es; x.e_busy = eb;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    // Winning source under the specification's rules, -1 when no grant.
    function automatic int winner(input int d);
        int start;
        if (rst || flush || (m_valid[d] && stall)) return -1;
        start = (d == 0) ? m_ptr[d] : 0;
        for (int k = 0; k < NS; k++) begin
            if (valid[(start + k) % NS]) return (start + k) % NS;
        end
        return -1;
    endfunction

    task automatic model_check(input int d);
        logic [2:0]  a_rdy   = d ? rdy_fx   : rdy_rr;
        logic        a_we    = d ? we_fx    : we_rr;
        logic [4:0]  a_waddr = d ? waddr_fx : waddr_rr;
        logic [31:0] a_wdata = d ? wdata_fx : wdata_rr;
        logic [1:0]  a_sel   = d ? sel_fx   : sel_rr;
        logic        a_busy  = d ? busy_fx  : busy_rr;
        int          w       = winner(d);
        logic        e_we    = !rst && m_valid[d] && !stall && (m_rd[d] != 5'd0);
        chk(d ? "fx_ready" : "rr_ready", 32'(a_rdy), (w >= 0) ? (32'd1 << w) : 32'd0);
        chk(d ? "fx_we" : "rr_we", 32'(a_we), 32'(e_we));
        chk(d ? "fx_busy" : "rr_busy", 32'(a_busy), 32'(m_valid[d]));
        if (e_we) begin
            chk(d ? "fx_waddr" : "rr_waddr", 32'(a_waddr), 32'(m_rd[d]));
            chk(d ? "fx_wdata" : "rr_wdata", a_wdata, m_data[d]);
            chk(d ? "fx_sel" : "rr_sel", 32'(a_sel), m_sel[d]);
        end
    endtask

    task automatic model_upd(input int d);
        int w = winner(d);
        if (rst) begin
            m_valid[d] = 1'b0; m_rd[d] = 5'd0; m_data[d] = 32'd0; m_sel[d] = 0; m_ptr[d] = 0;
        end else if (flush) begin
            m_valid[d] = 1'b0;
        end else if (w >= 0) begin
            m_valid[d] = 1'b1;
            m_rd[d]    = rd_bus[w*5 +: 5];
            m_data[d]  = data_bus[w*32 +: 32];
            m_sel[d]   = w;
            if (d == 0) m_ptr[d] = (w + 1) % NS;
        end else if (m_valid[d] && !stall) begin
            m_valid[d] = 1'b0;
        end
    endtask

    // Drive one cycle's inputs, check both DUTs against the model, advance the model.
    task automatic step(input logic r, input logic [2:0] v, input logic [4:0] a0,
                        input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] b,
                        input logic s, input logic f);
        @(negedge clk);
        rst = r; valid = v; stall = s; flush = f;
        rd_bus   = {a2, a1, a0};
        data_bus = {b + 32'd2, b + 32'd1, b};
        #1;
        model_check(0);
        model_check(1);
        model_upd(0);
        model_upd(1);
    endtask

    initial begin
        rst = 1'b1; valid = 3'b111; stall = 1'b0; flush = 1'b0;
        rd_bus = {5'd3, 5'd2, 5'd1}; data_bus = '0;
        for (int d = 0; d < 2; d++) begin
            m_valid[d] = 1'b0; m_rd[d] = 5'd0; m_data[d] = 32'd0; m_sel[d] = 0; m_ptr[d] = 0;
        end
        @(posedge clk);

        //             rst  valid   rd0   rd1   rd2   base           stl   fl    ready   we    waddr wdata          sel   busy
        vt[0]  = mk(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[1]  = mk(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[2]  = mk(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[3]  = mk(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b010, 1'b1, 5'd1, 32'h100,      2'd0, 1'b1);
        vt[4]  = mk(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b100, 1'b1, 5'd2, 32'h101,      2'd1, 1'b1);
        vt[5]  = mk(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b001, 1'b1, 5'd3, 32'h102,      2'd2, 1'b1);
        vt[6]  = mk(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b010, 1'b1, 5'd1, 32'h100,      2'd0, 1'b1);
        vt[7]  = mk(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b100, 1'b1, 5'd2, 32'h101,      2'd1, 1'b1);
        vt[8]  = mk(1'b0, 3'b000, 5'd1, 5'd2, 5'd3, 32'h100,      1'b0, 1'b0, 3'b000, 1'b1, 5'd3, 32'h102,      2'd2, 1'b1);
        vt[9]  = mk(1'b0, 3'b010, 5'd0, 5'd7, 5'd0, 32'hDEADBEEE, 1'b0, 1'b0, 3'b010, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[10] = mk(1'b0, 3'b000, 5'd0, 5'd7, 5'd0, 32'hDEADBEEE, 1'b0, 1'b0, 3'b000, 1'b1, 5'd7, 32'hDEADBEEF, 2'd1, 1'b1);
        vt[11] = mk(1'b0, 3'b001, 5'd0, 5'd0, 5'd0, 32'h1234,     1'b0, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[12] = mk(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h1234,     1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1);
        vt[13] = mk(1'b0, 3'b000, 5'd0, 5'd0, 5'd0, 32'h1234,     1'b0, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[14] = mk(1'b0, 3'b001, 5'd5, 5'd0, 5'd0, 32'h500,      1'b0, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[15] = mk(1'b0, 3'b100, 5'd5, 5'd0, 5'd6, 32'h600,      1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1);
        vt[16] = mk(1'b0, 3'b100, 5'd5, 5'd0, 5'd6, 32'h600,      1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1);
        vt[17] = mk(1'b0, 3'b100, 5'd5, 5'd0, 5'd6, 32'h600,      1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1);
        vt[18] = mk(1'b0, 3'b100, 5'd5, 5'd0, 5'd6, 32'h600,      1'b0, 1'b0, 3'b100, 1'b1, 5'd5, 32'h500,      2'd0, 1'b1);
        vt[19] = mk(1'b0, 3'b000, 5'd5, 5'd0, 5'd6, 32'h600,      1'b0, 1'b0, 3'b000, 1'b1, 5'd6, 32'h602,      2'd2, 1'b1);
        vt[20] = mk(1'b0, 3'b010, 5'd0, 5'd9, 5'd0, 32'h900,      1'b0, 1'b0, 3'b010, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[21] = mk(1'b0, 3'b001, 5'd4, 5'd9, 5'd0, 32'h400,      1'b1, 1'b1, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1);
        vt[22] = mk(1'b0, 3'b011, 5'd4, 5'd8, 5'd0, 32'h400,      1'b0, 1'b0, 3'b001, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[23] = mk(1'b0, 3'b000, 5'd4, 5'd8, 5'd0, 32'h400,      1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1);
        vt[24] = mk(1'b1, 3'b000, 5'd4, 5'd8, 5'd0, 32'h400,      1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b1);
        vt[25] = mk(1'b0, 3'b000, 5'd4, 5'd8, 5'd0, 32'h400,      1'b1, 1'b0, 3'b000, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[26] = mk(1'b0, 3'b100, 5'd0, 5'd0, 5'd3, 32'h0,        1'b0, 1'b0, 3'b100, 1'b0, 5'd0, 32'h0,        2'd0, 1'b0);
        vt[27] = mk(1'b0, 3'b000, 5'd0, 5'd0, 5'd3, 32'h0,        1'b0, 1'b0, 3'b000, 1'b1, 5'd3, 32'h2,        2'd2, 1'b1);

        for (int i = 0; i < 28; i++) begin
            step(vt[i].rst, vt[i].valid, vt[i].rd0, vt[i].rd1, vt[i].rd2, vt[i].base,
                 vt[i].stall, vt[i].flush);
            chk($sformatf("tbl%0d_ready", i), 32'(rdy_rr), 32'(vt[i].e_ready));
            chk($sformatf("tbl%0d_we", i), 32'(we_rr), 32'(vt[i].e_we));
            chk($sformatf("tbl%0d_busy", i), 32'(busy_rr), 32'(vt[i].e_busy));
            if (vt[i].e_we) begin
                chk($sformatf("tbl%0d_waddr", i), 32'(waddr_rr), 32'(vt[i].e_waddr));
                chk($sformatf("tbl%0d_wdata", i), wdata_rr, vt[i].e_wdata);
                chk($sformatf("tbl%0d_sel", i), 32'(sel_rr), 32'(vt[i].e_sel));
            end
        end

        // Fairness from a fresh reset: fixed mode always picks 0, round-robin rotates.
        step(1'b1, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) begin
            step(1'b0, 3'b111, 5'd1, 5'd2, 5'd3, 32'h100, 1'b0, 1'b0);
            chk($sformatf("fair_fx%0d", k), 32'(rdy_fx), 32'd1);
            chk($sformatf("fair_rr%0d", k), 32'(rdy_rr), 32'd1 << (k % 3));
        end

        for (int n = 0; n < 600; n++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 3'($urandom_range(0, 7)),
                 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 $urandom(),
                 ($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 9) == 0) ? 1'b1 : 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
